// File: rtl/run_len_detector.sv
// Purpose : flags a run of RUN_LEN equal bits on a serial input, with separate zero-run and one-run flags.
// Latency : out rises the cycle after the edge that samples the RUN_LEN-th equal bit; outputs are Moore, registered only.
// Backpressure: none; en gates sampling (en=0 holds all state), and clr gives a synchronous restart.
// Optional: define RUN_LEN_DETECTOR_STATS_EN to build the saturating match counter (match_cnt is tied to 0 otherwise).
module run_len_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 3,
    parameter int MATCH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic               mode,
    input  logic               in,
    output logic               out,
    output logic               out_zero,
    output logic               out_one,
    output logic               run_bit,
    output logic [CNT_W-1:0]   run_cnt,
    output logic [MATCH_W-1:0] match_cnt
);

    // The run counter must be able to hold RUN_LEN, and a zero-length run is meaningless.
    if (RUN_LEN < 1 || RUN_LEN > (2**CNT_W) - 1) begin : g_bad_run_len
        $error("run_len_detector: RUN_LEN must be in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // IDLE means that no bit has been sampled since reset or clr, so run_bit is not yet meaningful.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic             run_bit_q;
    logic             run_bit_nxt;
    logic [CNT_W-1:0] run_cnt_q;
    logic [CNT_W-1:0] run_cnt_nxt;

    // State, run bit and run counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            run_bit_q <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_nxt;
            run_bit_q <= run_bit_nxt;
            run_cnt_q <= run_cnt_nxt;
        end
    end

    // Next-state logic. clr beats en, and en=0 holds everything.
    always_comb begin
        state_nxt   = state_q;
        run_bit_nxt = run_bit_q;
        run_cnt_nxt = run_cnt_q;
        if (clr) begin
            state_nxt   = IDLE;
            run_bit_nxt = 1'b0;
            run_cnt_nxt = '0;
        end else if (en) begin
            unique case (state_q)
                IDLE: begin
                    state_nxt   = RUN;
                    run_bit_nxt = in;
                    run_cnt_nxt = CNT_ONE;
                end
                RUN: begin
                    if (in != run_bit_q) begin
                        // The run is broken: the new bit starts a fresh run of length one.
                        run_bit_nxt = in;
                        run_cnt_nxt = CNT_ONE;
                    end else if (!mode) begin
                        // Overlapping mode: saturate at RUN_LEN so that the flag stays up while the run continues.
                        if (run_cnt_q != RUN_LEN_C) begin
                            run_cnt_nxt = run_cnt_q + CNT_ONE;
                        end
                    end else begin
                        // Non-overlapping mode: after a match, restart the count at the current sample.
                        run_cnt_nxt = (run_cnt_q == RUN_LEN_C) ? CNT_ONE : run_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    run_bit_nxt = 1'b0;
                    run_cnt_nxt = '0;
                end
            endcase
        end
    end

`ifdef RUN_LEN_DETECTOR_STATS_EN
    logic               sat_hold;
    logic               match_hit;
    logic [MATCH_W-1:0] match_cnt_q;

    // A match is counted when a sample brings run_cnt to RUN_LEN. A sample that only holds the saturated overlapping count does not count.
    always_comb begin
        sat_hold  = (state_q == RUN) && (in == run_bit_q) && !mode && (run_cnt_q == RUN_LEN_C);
        match_hit = !clr && en && (run_cnt_nxt == RUN_LEN_C) && !sat_hold;
    end

    // Saturating match statistics counter. It is cleared by reset and clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_cnt_q <= '0;
        end else if (clr) begin
            match_cnt_q <= '0;
        end else if (match_hit && (match_cnt_q != {MATCH_W{1'b1}})) begin
            match_cnt_q <= match_cnt_q + MATCH_W'(1);
        end
    end

    assign match_cnt = match_cnt_q;
`else
    assign match_cnt = '0;
`endif

    // Moore outputs, decoded from the registered state only.
    assign out      = (state_q == RUN) && (run_cnt_q == RUN_LEN_C);
    assign out_zero = out & ~run_bit_q;
    assign out_one  = out & run_bit_q;
    assign run_bit  = run_bit_q;
    assign run_cnt  = run_cnt_q;

endmodule

// File: tb/tb_run_len_detector.sv
// Purpose : scoreboard bench for run_len_detector (RUN_LEN=4, CNT_W=3, MATCH_W=2).
// Latency : one expectation per clock edge, popped and compared 1 time unit after the edge.
// Backpressure: n/a; the bench drives en, clr and mode directly.
module tb_run_len_detector;

    localparam int RL   = 4;
    localparam int MMAX = 3;
`ifdef RUN_LEN_DETECTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       en;
    logic       clr;
    logic       mode;
    logic       din;
    logic       out;
    logic       out_zero;
    logic       out_one;
    logic       run_bit;
    logic [2:0] run_cnt;
    logic [1:0] match_cnt;

    run_len_detector #(.RUN_LEN(RL), .CNT_W(3), .MATCH_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .mode      (mode),
        .in        (din),
        .out       (out),
        .out_zero  (out_zero),
        .out_one   (out_one),
        .run_bit   (run_bit),
        .run_cnt   (run_cnt),
        .match_cnt (match_cnt)
    );

    typedef struct packed {
        logic       o;
        logic       oz;
        logic       oo;
        logic       rb;
        logic [2:0] rc;
        logic [1:0] mc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state.
    bit m_run;
    bit m_bit;
    int m_cnt;
    int m_match;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_bit   = 1'b0;
        m_cnt   = 0;
        m_match = 0;
    endtask

    task automatic step(input logic e, input logic c, input logic md, input logic d);
        exp_t x;
        bit   counted;
        en   = e;
        clr  = c;
        mode = md;
        din  = d;
        counted = 1'b0;
        if (c) begin
            model_reset();
        end else if (e) begin
            if (!m_run || d != m_bit) begin
                m_run   = 1'b1;
                m_bit   = d;
                m_cnt   = 1;
                counted = (RL == 1);
            end else if (!md) begin
                if (m_cnt < RL) begin
                    m_cnt   = m_cnt + 1;
                    counted = (m_cnt == RL);
                end
            end else begin
                m_cnt   = (m_cnt == RL) ? 1 : m_cnt + 1;
                counted = (m_cnt == RL);
            end
            if (STATS && counted && m_match < MMAX) m_match = m_match + 1;
        end
        x.o  = m_run && (m_cnt == RL);
        x.oz = x.o && !m_bit;
        x.oo = x.o && m_bit;
        x.rb = m_bit;
        x.rc = 3'(m_cnt);
        x.mc = 2'(m_match);
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("out", 32'(out), 32'(x.o));
        check("out_zero", 32'(out_zero), 32'(x.oz));
        check("out_one", 32'(out_one), 32'(x.oo));
        check("run_bit", 32'(run_bit), 32'(x.rb));
        check("run_cnt", 32'(run_cnt), 32'(x.rc));
        check("match_cnt", 32'(match_cnt), 32'(x.mc));
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        mode  = 1'b0;
        din   = 1'b0;
        model_reset();
        #12;
        check("rst_out", 32'(out), 32'd0);
        check("rst_run_cnt", 32'(run_cnt), 32'd0);
        check("rst_run_bit", 32'(run_bit), 32'd0);
        check("rst_match", 32'(match_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: overlapping mode, a run of zeros followed by a single one.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_out_pre", 32'(out), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_out_zero4", 32'(out_zero), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_out_zero5", 32'(out_zero), 32'd1);
        check("t1_cnt5", 32'(run_cnt), 32'd4);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("t1_out_brk", 32'(out), 32'd0);
        check("t1_bit_brk", 32'(run_bit), 32'd1);
        check("t1_cnt_brk", 32'(run_cnt), 32'd1);

        // Test 2: non-overlapping mode, eight ones.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            check("t2_cnt", 32'(run_cnt), 32'((i % 4) + 1));
            check("t2_out_one", 32'(out_one), 32'((i == 3 || i == 7) ? 1 : 0));
        end
        check("t2_match", 32'(match_cnt), STATS ? 32'd2 : 32'd0);

        // Test 3: a gap in the enable is ignored.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("t3_out_pre", 32'(out), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("t3_out", 32'(out), 32'd1);

        // Test 4: asynchronous reset in the middle of a run.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("t4_async_out", 32'(out), 32'd0);
        check("t4_async_cnt", 32'(run_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_out_pre", 32'(out), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_out", 32'(out), 32'd1);

        // Test 5: clr takes priority over an enabled sample.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_cnt_pre", 32'(run_cnt), 32'd3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("t5_cnt", 32'(run_cnt), 32'd0);
        check("t5_out", 32'(out), 32'd0);

        // Test 6: saturation of the match counter.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("t6_match", 32'(match_cnt), STATS ? 32'd3 : 32'd0);

        // Random traffic with runs, enable gaps, clears and mode flips.
        for (int i = 0; i < 400; i++) begin
            logic e;
            logic c;
            logic md;
            logic d;
            e  = ($urandom_range(3) != 0);
            c  = ($urandom_range(19) == 0);
            md = (i / 50) % 2 == 1 ? ($urandom_range(7) != 0) : ($urandom_range(7) == 0);
            d  = ($urandom_range(4) == 0) ? ~m_bit : m_bit;
            step(e, c, md, d);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
